// File: rtl/hsv_core_fetch_queue.sv
// hsv_core_fetch_queue: fetch response FIFO to decode; define HSV_FETCH_QUEUE_BYPASS_EN for zero-latency empty-queue bypass
module hsv_core_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_core,
  input  logic                       rst_core_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_insn,
  input  logic                       in_fault,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_insn,
  output logic                       out_fault,
  output logic                       out_bad_len,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   insn_mem [DEPTH];
  logic          fault_mem[DEPTH];
  logic          empty, full, push, pop, wr_en, byp;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  // status, handshakes and head-entry presentation
  always_comb begin
    empty    = wr_ptr == rd_ptr;
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    in_ready = !full && !flush;
    push     = in_valid && in_ready;
`ifdef HSV_FETCH_QUEUE_BYPASS_EN
    byp       = empty && !flush && in_valid;
    out_pc    = byp ? in_pc    : pc_mem[rd_idx];
    out_insn  = byp ? in_insn  : insn_mem[rd_idx];
    out_fault = byp ? in_fault : fault_mem[rd_idx];
`else
    byp       = 1'b0;
    out_pc    = pc_mem[rd_idx];
    out_insn  = insn_mem[rd_idx];
    out_fault = fault_mem[rd_idx];
`endif
    out_valid   = (!empty && !flush) || byp;
    out_bad_len = out_insn[1:0] != 2'b11;
    pop         = out_valid && out_ready && !empty;
    wr_en       = push && !(byp && out_ready);
    count       = wr_ptr - rd_ptr;
  end
  // pointers: flush and reset rewind both to zero
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  // entry storage, deliberately not reset
  always_ff @(posedge clk_core) begin
    if (wr_en) begin
      pc_mem[wr_idx]    <= in_pc;
      insn_mem[wr_idx]  <= in_insn;
      fault_mem[wr_idx] <= in_fault;
    end
  end
endmodule

// File: tb/tb_hsv_core_fetch_queue.sv
// tb_hsv_core_fetch_queue: directed and randomized checks of the fetch queue against a queue-based model
module tb_hsv_core_fetch_queue;
  localparam int DEPTH = 4;
  logic clk_core = 1'b0;
  logic rst_core_n, flush, in_valid, in_fault, out_ready;
  logic in_ready, out_valid, out_fault, out_bad_len;
  logic [31:0] in_pc, in_insn, out_pc, out_insn;
  logic [$clog2(DEPTH):0] count;
  int errs = 0;
  int checks = 0;
  int pops = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } ent_t;
  ent_t q[$];

  hsv_core_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn),
    .out_fault(out_fault), .out_bad_len(out_bad_len), .count(count)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk_core);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] insn, input logic f);
    in_valid = v;
    in_pc    = pc;
    in_insn  = insn;
    in_fault = f;
  endtask

  // model: check outputs mid-cycle, then apply what the coming edge will do
  always @(negedge clk_core) begin
    if (!rst_core_n) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
    end else begin
      logic       ev, er;
      logic [1:0] lo;
      ev = q.size() > 0 && !flush;
      er = q.size() < DEPTH && !flush;
      chk("m_out_valid", 32'(out_valid), 32'(ev));
      chk("m_in_ready", 32'(in_ready), 32'(er));
      chk("m_count", 32'(count), q.size());
      if (ev) begin
        lo = q[0].insn[1:0];
        chk("m_out_pc", out_pc, q[0].pc);
        chk("m_out_insn", out_insn, q[0].insn);
        chk("m_out_fault", 32'(out_fault), 32'(q[0].fault));
        chk("m_out_bad_len", 32'(out_bad_len), 32'(lo != 2'b11));
      end
      if (flush) q.delete();
      else begin
        if (ev && out_ready) begin
          void'(q.pop_front());
          pops++;
        end
        if (er && in_valid) q.push_back('{in_pc, in_insn, in_fault});
      end
    end
  end

  initial begin
    rst_core_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    put(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step;
    rst_core_n = 1'b1;
    step;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    // single entry latency
    out_ready = 1'b1;
    put(1'b1, 32'h100, 32'h00000013, 1'b0);
    #1 chk("lat_not_same_cycle", 32'(out_valid), 32'd0);
    step;
    put(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_pc", out_pc, 32'h100);
    chk("lat_out_insn", out_insn, 32'h00000013);
    chk("lat_bad_len", 32'(out_bad_len), 32'd0);
    step;
    chk("lat_drained", 32'(count), 32'd0);
    // fill beyond capacity then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 32'(i * 4), 32'h13 | 32'(i << 7), 1'b0);
      step;
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    put(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_pc", out_pc, 32'(i * 4));
      step;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    // full with simultaneous push attempt and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'h20 + 32'(i * 4), 32'h33, 1'b0);
      step;
    end
    put(1'b1, 32'h40, 32'h33, 1'b0);
    out_ready = 1'b1;
    #1 chk("fullpop_in_ready", 32'(in_ready), 32'd0);
    step;
    chk("fullpop_count", 32'(count), 32'd3);
    out_ready = 1'b0;
    step;
    chk("refill_count", 32'(count), 32'd4);
    put(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    repeat (4) step;
    chk("refill_drained", 32'(count), 32'd0);
    // flush with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 32'h80 + 32'(i * 4), 32'h13, 1'b0);
      step;
    end
    put(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step;
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    put(1'b1, 32'h200, 32'h13, 1'b0);
    step;
    put(1'b0, 32'h0, 32'h0, 1'b0);
    #1 chk("flush_first_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    step;
    // compressed encoding with bus error
    put(1'b1, 32'h300, 32'h00004501, 1'b1);
    step;
    put(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("c_bad_len", 32'(out_bad_len), 32'd1);
    chk("c_fault", 32'(out_fault), 32'd1);
    step;
    // asynchronous reset with two entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      put(1'b1, 32'h400 + 32'(i * 4), 32'h13, 1'b0);
      step;
    end
    put(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    rst_core_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    step;
    rst_core_n = 1'b1;
    step;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    // randomized traffic with phases biased toward full and empty
    pops = 0;
    for (int c = 0; c < 10000; c++) begin
      int pin, pout;
      pin  = ((c / 250) % 3 == 0) ? 85 : ((c / 250) % 3 == 1) ? 30 : 60;
      pout = ((c / 250) % 3 == 0) ? 30 : ((c / 250) % 3 == 1) ? 85 : 60;
      put($urandom_range(99) < pin, $urandom, $urandom, 1'($urandom_range(1)));
      out_ready = $urandom_range(99) < pout;
      flush = $urandom_range(199) == 0;
      step;
    end
    flush = 1'b0;
    put(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    repeat (DEPTH + 2) step;
    chk("random_wraps", 32'(pops > 16 * DEPTH), 32'd1);
    chk("final_count", 32'(count), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
